// File: rtl/mem_requester_if.sv
// Memory request/acknowledge bus between the CPU-side requester (master)
// and the memory responder (slave).
interface mem_requester_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_requester.sv
// CPU-side memory initiator: fetch, load/store and push/pop over a req/ack bus.
// Define MEM_TIMEOUT_EN to add the ack-wait timeout with sticky err flag.
module mem_requester #(
  parameter int unsigned    AW      = 8,
  parameter int unsigned    DW      = 32,
  parameter logic [AW-1:0]  SP_INIT = '0,
  parameter int unsigned    TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    phase,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] ma,
  input  logic [DW-1:0] md_in,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] mdr,
  output logic [AW-1:0] sp,
  output logic          stall,
  output logic          done,
  output logic          err,
  mem_requester_if.master mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {K_FETCH, K_LOAD, K_STORE, K_PUSH, K_POP} kind_e;

  state_e        state_q;
  kind_e         kind_q;
  logic [4:0]    phase_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] mdr_q;
  logic [AW-1:0] sp_q;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          done_q;

  logic is_load, is_store, is_push, is_pop, mem_op;
  logic start_f, start_m;

  always_comb begin
    is_store = (ir_q[31:24] == 8'h8B);
    is_load  = (ir_q[31:24] == 8'h89);
    is_push  = (ir_q[31:19] == 13'h120A);
    is_pop   = (ir_q[31:19] == 13'h120B);
    mem_op   = is_load | is_store | is_push | is_pop;
    start_f  = phase[4] & ~phase_q[4];
    start_m  = phase[1] & ~phase_q[1] & mem_op;
  end

  assign stall = start_f | start_m | (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= K_FETCH;
      phase_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      sp_q    <= SP_INIT;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase;
      case (state_q)
        IDLE: begin
`ifdef MEM_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (start_f) begin
            state_q <= BUSY;
            kind_q  <= K_FETCH;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc;
          end else if (start_m) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            if (is_store) begin
              kind_q  <= K_STORE;
              we_q    <= 1'b1;
              addr_q  <= ma;
              wdata_q <= md_in;
            end else if (is_load) begin
              kind_q  <= K_LOAD;
              we_q    <= 1'b0;
              addr_q  <= ma;
            end else if (is_push) begin
              // Pre-decrement push: write lands at sp-1, sp commits on ack.
              kind_q  <= K_PUSH;
              we_q    <= 1'b1;
              addr_q  <= sp_q - 1'b1;
              wdata_q <= md_in;
            end else begin
              kind_q  <= K_POP;
              we_q    <= 1'b0;
              addr_q  <= sp_q;
            end
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            case (kind_q)
              K_FETCH: ir_q  <= mem.mem_rdata;
              K_LOAD:  mdr_q <= mem.mem_rdata;
              K_PUSH:  sp_q  <= sp_q - 1'b1;
              K_POP: begin
                mdr_q <= mem.mem_rdata;
                sp_q  <= sp_q + 1'b1;
              end
              default: ;
            endcase
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ir            = ir_q;
  assign mdr           = mdr_q;
  assign sp            = sp_q;
  assign done          = done_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  logic unused_bits;
`ifdef MEM_TIMEOUT_EN
  assign unused_bits = ^{phase[3:2], phase[0], phase_q[3:2], phase_q[0]};
`else
  assign unused_bits = ^{phase[3:2], phase[0], phase_q[3:2], phase_q[0], (TIMEOUT == 0)};
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Directed self-checking bench for mem_requester (default build and MEM_TIMEOUT_EN).
module tb_mem_requester;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam logic [4:0] PH_F = 5'b10000;
  localparam logic [4:0] PH_M = 5'b00010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    phase;
  logic [AW-1:0] pc, ma, sp;
  logic [DW-1:0] md_in, ir, mdr;
  logic          stall, done, err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_requester_if #(.AW(AW), .DW(DW)) mif ();

  mem_requester #(.AW(AW), .DW(DW), .SP_INIT(8'h00), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .phase(phase), .pc(pc), .ma(ma), .md_in(md_in),
    .ir(ir), .mdr(mdr), .sp(sp), .stall(stall), .done(done), .err(err),
    .mem(mif.master)
  );

  always #5 clk = ~clk;

  // Stimulus only: fetch one instruction with an immediate ack, then drop phase.
  task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk) phase = PH_F; pc = a; mif.mem_ack = 1'b0;
    @(negedge clk) mif.mem_ack = 1'b1; mif.mem_rdata = d;
    @(negedge clk) mif.mem_ack = 1'b0;
    @(negedge clk) phase = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phase = '0; pc = '0; ma = '0; md_in = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    #1;
    n_checks++; if ({ir, mdr} !== 64'h0) begin n_fail++; $display("FAIL reset_ir_mdr: got %h/%h expected 0/0", ir, mdr); end
    n_checks++; if (sp !== 8'h00) begin n_fail++; $display("FAIL reset_sp: got %h expected 00", sp); end
    n_checks++; if ({mif.mem_req, mif.mem_we, done, err, stall} !== 5'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got req/we/done/err/stall=%b expected 00000", {mif.mem_req, mif.mem_we, done, err, stall}); end
    n_checks++; if ({mif.mem_addr, mif.mem_wdata} !== 40'h0) begin n_fail++;
      $display("FAIL reset_bus: got addr %h wdata %h expected 0/0", mif.mem_addr, mif.mem_wdata); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    @(negedge clk) phase = PH_F; pc = 8'h10; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_start_stall: got %b expected 1", stall); end
    @(negedge clk);
    n_checks++; if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {2'b10, 8'h10}) begin n_fail++;
      $display("FAIL fetch_req: got req %b we %b addr %h expected 1 0 10", mif.mem_req, mif.mem_we, mif.mem_addr); end
    @(negedge clk);
    n_checks++; if ({mif.mem_req, stall, done} !== 3'b110) begin n_fail++;
      $display("FAIL fetch_wait2: got req/stall/done %b expected 110", {mif.mem_req, stall, done}); end
    @(negedge clk);
    n_checks++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 8'h10}) begin n_fail++;
      $display("FAIL fetch_wait3: got req %b addr %h expected 1 10", mif.mem_req, mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h8900_0000;
    @(negedge clk) mif.mem_ack = 1'b0;
    n_checks++; if (ir !== 32'h8900_0000) begin n_fail++; $display("FAIL fetch_ir: got %h expected 89000000", ir); end
    n_checks++; if ({mif.mem_req, done, stall} !== 3'b010) begin n_fail++;
      $display("FAIL fetch_done_cycle: got req/done/stall %b expected 010", {mif.mem_req, done, stall}); end
    @(negedge clk);
    n_checks++; if ({mif.mem_req, done, stall} !== 3'b000) begin n_fail++;
      $display("FAIL fetch_no_retrigger: got req/done/stall %b expected 000", {mif.mem_req, done, stall}); end
    phase = '0;
    @(negedge clk);
  endtask

  task automatic test_load_store();
    @(negedge clk) phase = PH_M; ma = 8'h20; mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_start_stall: got %b expected 1", stall); end
    @(negedge clk);
    n_checks++; if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {2'b10, 8'h20}) begin n_fail++;
      $display("FAIL load_req: got req %b we %b addr %h expected 1 0 20", mif.mem_req, mif.mem_we, mif.mem_addr); end
    @(negedge clk) mif.mem_ack = 1'b0;
    n_checks++; if ({done, mif.mem_req, mdr} !== {2'b10, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL load_done: got done %b req %b mdr %h expected 1 0 deadbeef", done, mif.mem_req, mdr); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_done_pulse: got %b expected 0", done); end
    phase = '0;
    @(negedge clk);
    do_fetch(8'h30, 32'h8B00_0000);
    @(negedge clk) phase = PH_M; ma = 8'h20; md_in = 32'h0000_1234;
    @(negedge clk);
    n_checks++; if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata} !== {2'b11, 8'h20, 32'h0000_1234}) begin n_fail++;
      $display("FAIL store_req: got req %b we %b addr %h wdata %h expected 1 1 20 00001234",
               mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk) mif.mem_ack = 1'b0;
    n_checks++; if ({done, mdr} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL store_mdr_kept: got done %b mdr %h expected 1 deadbeef", done, mdr); end
    phase = '0;
    @(negedge clk);
  endtask

  task automatic test_push_pop_wrap();
    do_fetch(8'h40, 32'h9050_0000);
    @(negedge clk) phase = PH_M; md_in = 32'h0000_00A5;
    @(negedge clk);
    n_checks++; if ({mif.mem_we, mif.mem_addr, mif.mem_wdata} !== {1'b1, 8'hFF, 32'h0000_00A5}) begin n_fail++;
      $display("FAIL push_req: got we %b addr %h wdata %h expected 1 ff 000000a5", mif.mem_we, mif.mem_addr, mif.mem_wdata); end
    mif.mem_ack = 1'b1;
    @(negedge clk) mif.mem_ack = 1'b0;
    n_checks++; if ({done, sp} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL push_sp: got done %b sp %h expected 1 ff", done, sp); end
    phase = '0;
    @(negedge clk);
    do_fetch(8'h41, 32'h9058_0000);
    @(negedge clk) phase = PH_M;
    @(negedge clk);
    n_checks++; if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {2'b10, 8'hFF}) begin n_fail++;
      $display("FAIL pop_req: got req %b we %b addr %h expected 1 0 ff", mif.mem_req, mif.mem_we, mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_00A5;
    @(negedge clk) mif.mem_ack = 1'b0;
    n_checks++; if ({mdr, sp} !== {32'h0000_00A5, 8'h00}) begin n_fail++;
      $display("FAIL pop_result: got mdr %h sp %h expected 000000a5 00", mdr, sp); end
    phase = '0;
    @(negedge clk);
  endtask

  task automatic test_non_mem_op();
    do_fetch(8'h50, 32'h0000_0000);
    @(negedge clk) phase = PH_M; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nonmem_stall: got %b expected 0", stall); end
    @(negedge clk);
    n_checks++; if ({mif.mem_req, done, stall} !== 3'b000) begin n_fail++;
      $display("FAIL nonmem_idle: got req/done/stall %b expected 000", {mif.mem_req, done, stall}); end
    @(negedge clk);
    n_checks++; if ({mif.mem_req, done} !== 2'b00) begin n_fail++;
      $display("FAIL nonmem_idle2: got req/done %b expected 00", {mif.mem_req, done}); end
    phase = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    do_fetch(8'h60, 32'h9050_0000);
    @(negedge clk) phase = PH_M; md_in = 32'h1;
    @(negedge clk) mif.mem_ack = 1'b1;
    @(negedge clk) mif.mem_ack = 1'b0; phase = '0;
    n_checks++; if (sp !== 8'hFF) begin n_fail++; $display("FAIL rbusy_pre_sp: got %h expected ff", sp); end
    @(negedge clk) phase = PH_F; pc = 8'h70;
    @(negedge clk);
    n_checks++; if (mif.mem_req !== 1'b1) begin n_fail++; $display("FAIL rbusy_busy: got req %b expected 1", mif.mem_req); end
    #2 rst_n = 1'b0; #1;
    n_checks++; if ({mif.mem_req, sp, ir} !== {1'b0, 8'h00, 32'h0}) begin n_fail++;
      $display("FAIL rbusy_async: got req %b sp %h ir %h expected 0 00 00000000", mif.mem_req, sp, ir); end
    @(negedge clk) phase = '0;
    @(negedge clk) rst_n = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    n_checks++; if ({mif.mem_req, done, ir} !== {2'b00, 32'h0}) begin n_fail++;
      $display("FAIL rbusy_late_ack: got req %b done %b ir %h expected 0 0 00000000", mif.mem_req, done, ir); end
    mif.mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int unsigned req_cycles;
    req_cycles = 0;
    do_fetch(8'h80, 32'h8900_0000);
    @(negedge clk) phase = PH_F; pc = 8'h90;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.mem_req) req_cycles++;
      else break;
    end
    n_checks++; if (req_cycles !== 16) begin n_fail++; $display("FAIL timeout_len: got %0d req cycles expected 16", req_cycles); end
    n_checks++; if ({mif.mem_req, err, done, ir} !== {3'b011, 32'h8900_0000}) begin n_fail++;
      $display("FAIL timeout_flags: got req %b err %b done %b ir %h expected 0 1 1 89000000", mif.mem_req, err, done, ir); end
    phase = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({err, done} !== 2'b10) begin n_fail++; $display("FAIL timeout_sticky: got err %b done %b expected 1 0", err, done); end
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.mem_req) req_cycles++;
    end
    n_checks++; if (req_cycles !== 40) begin n_fail++; $display("FAIL noto_wait: got %0d req cycles expected 40", req_cycles); end
    n_checks++; if ({mif.mem_req, stall, err, done} !== 4'b1100) begin n_fail++;
      $display("FAIL noto_state: got req/stall/err/done %b expected 1100", {mif.mem_req, stall, err, done}); end
`endif
    rst_n = 1'b0; phase = '0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_store();
    test_push_pop_wrap();
    test_non_mem_op();
    test_reset_busy();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
